// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default datapath width and the
// occupancy states of the result-stage skid buffer.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_ILL = 3'b111
  } alu_op_e;

  // EMPTY: nothing held; ONE: output register valid; FULL: output + skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU functional units / writeback and the result stage.
//   Upstream  : in_valid, in_ready, alu_op, and/or/xor/nor/add/sub_res, a_msb, b_msb
//   Downstream: out_valid, out_ready, result, zero, neg, ovf, illegal, retired
// slave  : the result stage's view.
// master : the surrounding pipeline's (or a bench's) view.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] xor_res;
  logic [WIDTH-1:0] nor_res;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  in_valid, alu_op, and_res, or_res, xor_res, nor_res, add_res, sub_res,
           a_msb, b_msb, out_ready,
    output in_ready, out_valid, result, zero, neg, ovf, illegal, retired
  );

  modport master (
    output in_valid, alu_op, and_res, or_res, xor_res, nor_res, add_res, sub_res,
           a_msb, b_msb, out_ready,
    input  in_ready, out_valid, result, zero, neg, ovf, illegal, retired
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational result select and flag derivation for the ALU result stage.
//   op_i            : decoded opcode
//   *_res_i         : precomputed functional-unit results
//   a_msb_i/b_msb_i : operand sign bits (for overflow / SLT)
//   result_o, zero_o, neg_o, ovf_o, illegal_o : selected result and flags
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] and_res_i,
  input  logic [WIDTH-1:0] or_res_i,
  input  logic [WIDTH-1:0] xor_res_i,
  input  logic [WIDTH-1:0] nor_res_i,
  input  logic [WIDTH-1:0] add_res_i,
  input  logic [WIDTH-1:0] sub_res_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic             illegal_o
);

  logic add_ovf;
  logic sub_ovf;

  assign add_ovf = (a_msb_i == b_msb_i) && (add_res_i[WIDTH-1] != a_msb_i);
  assign sub_ovf = (a_msb_i != b_msb_i) && (sub_res_i[WIDTH-1] != a_msb_i);

  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_AND: result_o = and_res_i;
      OP_OR:  result_o = or_res_i;
      OP_XOR: result_o = xor_res_i;
      OP_NOR: result_o = nor_res_i;
      OP_ADD: begin
        result_o = add_res_i;
        ovf_o    = add_ovf;
      end
      OP_SUB: begin
        result_o = sub_res_i;
        ovf_o    = sub_ovf;
      end
      // Signed less-than: the true sign of A-B is the raw sign corrected by overflow.
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, sub_res_i[WIDTH-1] ^ sub_ovf};
      OP_ILL: illegal_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign neg_o  = result_o[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage with a one-entry skid buffer and a saturating
// retired-op counter.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; drops both held entries
//   bus   : upstream handshake + unit results, downstream result + flags
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             illegal;
  } entry_t;

  stage_state_e     state_q, state_d;
  entry_t           new_e;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic deliver;
  logic load_out_new;
  logic load_out_skid;
  logic load_skid;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op_i      (alu_op_e'(bus.alu_op)),
    .and_res_i (bus.and_res),
    .or_res_i  (bus.or_res),
    .xor_res_i (bus.xor_res),
    .nor_res_i (bus.nor_res),
    .add_res_i (bus.add_res),
    .sub_res_i (bus.sub_res),
    .a_msb_i   (bus.a_msb),
    .b_msb_i   (bus.b_msb),
    .result_o  (new_e.result),
    .zero_o    (new_e.zero),
    .neg_o     (new_e.neg),
    .ovf_o     (new_e.ovf),
    .illegal_o (new_e.illegal)
  );

  assign accept  = bus.in_valid && in_ready;
  assign deliver = out_valid && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (bus.out_ready) state_d = accept ? ST_ONE : ST_EMPTY;
        else if (accept)   state_d = ST_FULL;
      end
      ST_FULL:  if (bus.out_ready) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Outputs and datapath load controls; in_ready depends only on state so
  // out_ready never reaches it combinationally.
  always_comb begin
    in_ready      = 1'b1;
    out_valid     = 1'b0;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      ST_EMPTY: load_out_new = accept;
      ST_ONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) load_out_new = accept;
        else               load_skid    = accept;
      end
      ST_FULL: begin
        in_ready      = 1'b0;
        out_valid     = 1'b1;
        load_out_skid = bus.out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (load_out_new)  out_d  = new_e;
    if (load_out_skid) out_d  = skid_q;
    if (load_skid)     skid_d = new_e;
  end

  always_comb begin
    retired_d = retired_q;
    if (deliver && (retired_q != '1)) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      skid_q    <= '0;
      retired_q <= '0;
    end else begin
      out_q     <= out_d;
      skid_q    <= skid_d;
      retired_q <= retired_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = out_q.result;
  assign bus.zero      = out_q.zero;
  assign bus.neg       = out_q.neg;
  assign bus.ovf       = out_q.ovf;
  assign bus.illegal   = out_q.illegal;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic clk;
  logic reset;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus  ();
  alu_result_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  alu_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshake log of the main DUT, for the ordering check.
  logic [31:0] log_q[$];
  always @(posedge clk)
    if (!reset && bus.out_valid && bus.out_ready) log_q.push_back(bus.result);

  typedef struct {
    logic [2:0]  op;
    logic [31:0] val;
    logic        am;
    logic        bm;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        o;
    logic        il;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Put val on the lane the opcode selects; decoys elsewhere expose a bad mux.
  task automatic drive(input logic [2:0] op, input logic [31:0] val, input logic am, input logic bm);
    bus.alu_op  = op;
    bus.and_res = 32'h1111_1111;
    bus.or_res  = 32'h2222_2222;
    bus.xor_res = 32'h3333_3333;
    bus.nor_res = 32'h4444_4444;
    bus.add_res = 32'h5555_5555;
    bus.sub_res = 32'h6666_6666;
    bus.a_msb   = am;
    bus.b_msb   = bm;
    case (op)
      3'b000:  bus.and_res = val;
      3'b001:  bus.or_res  = val;
      3'b010:  bus.xor_res = val;
      3'b011:  bus.nor_res = val;
      3'b100:  bus.add_res = val;
      default: bus.sub_res = val;
    endcase
  endtask

  initial begin
    //            op      val            am    bm    res           z     n     o     il
    vecs[0]  = '{3'b000, 32'h0000_00F0, 1'b0, 1'b0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 32'h8000_0001, 1'b1, 1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'b100, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'b101, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3'b101, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'b110, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b111, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'b000, 32'h0, 1'b0, 1'b0);
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.alu_op    = 3'b010;
    bus4.and_res   = '0;
    bus4.or_res    = '0;
    bus4.xor_res   = '0;
    bus4.nor_res   = '0;
    bus4.add_res   = '0;
    bus4.sub_res   = '0;
    bus4.a_msb     = 1'b0;
    bus4.b_msb     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset result",    bus.result,         32'd0);
    check("reset flags",     {28'd0, bus.zero, bus.neg, bus.ovf, bus.illegal}, 32'd0);
    check("reset retired",   32'(bus.retired),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single ops, full throughput downstream.
    for (int unsigned i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].val, vecs[i].am, vecs[i].bm);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d result", i), bus.result, vecs[i].res);
      check($sformatf("vec%0d z/n/o/il", i),
            {28'd0, bus.zero, bus.neg, bus.ovf, bus.illegal},
            {28'd0, vecs[i].z, vecs[i].n, vecs[i].o, vecs[i].il});
      check($sformatf("vec%0d retired", i), 32'(bus.retired), i);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("after table out_valid", 32'(bus.out_valid), 32'd0);
    check("after table retired", 32'(bus.retired), 32'd15);

    // Backpressure: three back-to-back ops against a stalled output.
    log_q.delete();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(3'b010, 32'd1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp op1 out_valid", 32'(bus.out_valid), 32'd1);
    check("bp op1 result", bus.result, 32'd1);
    check("bp op1 in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(3'b010, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp full in_ready", 32'(bus.in_ready), 32'd0);
    check("bp held result", bus.result, 32'd1);
    @(negedge clk);
    drive(3'b010, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp stall in_ready", 32'(bus.in_ready), 32'd0);
    check("bp stall result", bus.result, 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp drain1 result", bus.result, 32'd2);
    check("bp drain1 in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp drain2 result", bus.result, 32'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp drained out_valid", 32'(bus.out_valid), 32'd0);
    check("bp log size", log_q.size(), 32'd3);
    for (int unsigned k = 0; k < 3; k++)
      check($sformatf("bp order %0d", k), (k < log_q.size()) ? log_q[k] : 32'hXXXX_XXXX, k + 1);
    check("bp retired", 32'(bus.retired), 32'd18);

    // Reset while FULL drops both entries.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(3'b010, 32'd7, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(3'b010, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre-reset full in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    check("mid reset retired", 32'(bus.retired), 32'd0);
    check("mid reset result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post reset out_valid", 32'(bus.out_valid), 32'd0);
    check("post reset retired", 32'(bus.retired), 32'd0);

    // Saturation on the 4-bit counter instance.
    for (int unsigned n = 1; n <= 22; n++) begin
      @(negedge clk);
      bus4.xor_res  = n;
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      if (n == 15) check("sat retired at 14", 32'(bus4.retired), 32'd14);
      if (n == 16) check("sat retired at 15", 32'(bus4.retired), 32'd15);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat retired held", 32'(bus4.retired), 32'd15);
    check("sat out_valid idle", 32'(bus4.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage of the 32-bit ALU. It sits directly downstream of the bitwise units (and/or/xor/nor) and the adder/subtractor.
- Selects the result for the issued op, derives flags (zero, negative, overflow, set-less-than) and presents them to the writeback stage.
- Valid/ready handshake with a one-entry skid buffer, so full throughput holds under backpressure.
- Keeps a saturating count of retired ops.

Parameters:
- WIDTH, 32, datapath width in bits.
- CNT_W, 16, width of the retired-op counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a valid op this cycle.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 illegal.
- and_res  in  WIDTH  bitwise AND result.
- or_res  in  WIDTH  bitwise OR result.
- xor_res  in  WIDTH  bitwise XOR result.
- nor_res  in  WIDTH  bitwise NOR result.
- add_res  in  WIDTH  A+B mod 2^WIDTH.
- sub_res  in  WIDTH  A-B mod 2^WIDTH.
- a_msb  in  1  operand A sign bit.
- b_msb  in  1  operand B sign bit.
- out_valid  out  1  result held on outputs is valid.
- out_ready  in  1  downstream accepts this cycle.
- result  out  WIDTH  selected result.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].
- ovf  out  1  signed overflow; ADD/SUB only, else 0.
- illegal  out  1  alu_op was 111.
- retired  out  CNT_W  saturating count of output handshakes.

Behaviour:
- Reset: out_valid=0, in_ready=1, result=0, zero=0, neg=0, ovf=0, illegal=0, retired=0, skid buffer empty. Reset mid-transfer drops both held entries; no partial output.
- Accept: an op is accepted when in_valid && in_ready. Output: an op is delivered when out_valid && out_ready.
- Latency: 1 cycle from accept to out_valid when the output register is empty or draining. Throughput is 1 op/cycle while out_ready=1.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- Next-state for the output register (out_reg) and skid register (skid), evaluated each cycle in this order:
  - EMPTY (out_valid=0, skid_valid=0): accept -> out_reg; go to ONE.
  - ONE (out_valid=1, skid_valid=0):
    - out_ready=1: out_reg takes the accepted op if any, else becomes empty.
    - out_ready=0 with accept: new op -> skid; go to FULL.
    - out_ready=0 without accept: hold.
  - FULL (out_valid=1, skid_valid=1): in_ready=0, no accept. out_ready=1: skid -> out_reg; go to ONE. out_ready=0: hold.
- Ordering: strictly in order; a held output never changes while out_valid && !out_ready.
- Flags are computed at accept time and stored with the result:
  - ADD: ovf = (a_msb==b_msb) && (add_res[MSB]!=a_msb).
  - SUB: ovf = (a_msb!=b_msb) && (sub_res[MSB]!=a_msb).
  - SLT: result = {WIDTH-1 zeros, sub_res[MSB] ^ sub_ovf}; ovf=0.
  - Bitwise ops: ovf=0.
  - 111: result=0, zero=1, neg=0, ovf=0, illegal=1; the op still flows and retires.
  - zero and neg always reflect the stored result.
- retired increments by 1 on each output handshake and saturates at 2^CNT_W-1 (no wrap).

Decomposition:
- Shared package alu_pkg: opcode constants (OP_AND..OP_ILL) and the WIDTH default, reused by the ALU control decoder.
- Sub-module alu_flag_gen (combinational): result mux, ovf/slt/zero/neg. The top holds the skid FSM, registers and counter.

Test Plan:
- XOR pass-through: alu_op=010, xor_res=32'hA5A5_5A5A, out_ready=1 -> next cycle out_valid=1, result=32'hA5A5_5A5A, zero=0, neg=1, ovf=0.
- ADD overflow: alu_op=100, a_msb=0, b_msb=0, add_res=32'h8000_0000 -> ovf=1, neg=1. SUB with a_msb=1, b_msb=0, sub_res=32'h7FFF_FFFF -> ovf=1.
- SLT: a=-1, b=1 (sub_res=32'hFFFF_FFFE, a_msb=1, b_msb=0) -> result=1. a=32'h8000_0000, b=1 (sub_res=32'h7FFF_FFFF, ovf) -> result=1.
- Backpressure: 3 back-to-back ops with out_ready=0 -> op1 held, op2 in skid, in_ready=0 from cycle 3. Raise out_ready -> op1, op2, op3 emerge in order, with no loss or duplication.
- Illegal/reset: alu_op=111 -> result=0, zero=1, illegal=1, retired+1. Assert reset while FULL -> next cycle out_valid=0, in_ready=1, retired=0.
- Saturation: CNT_W=4, 20 handshakes -> retired=15 and stays 15.
